demux_stream_dispatcher: RTL and testbench
==========================================

// Module: demux_stream_dispatcher
// PURPOSE
//  Sequencer that owns the 1-to-2 demux path and turns it into a registered stream dispatcher.
//  - Accepts one data word per valid/ready handshake.
//  - Holds the word in a one-entry buffer.
//  - Routes it to exactly one of two consumers, chosen by an explicit steer bit or by round-robin.
//  - The inactive output carries zero data, matching demux semantics.
//  Sits between a single producer and two downstream consumers (e.g. two ALU lanes or two FIFOs).
// PARAMETERS
//  WIDTH  8  data word width in bits
//  CNT_W  8  width of per-output dispatch counters (only with DISPATCH_COUNT_EN)
// PORTS
//  CLK        in   1      single clock; all state updates on rising edge
//  RST        in   1      reset, synchronous, active-high
//  MODE       in   1      0 = steer by IN_SEL, 1 = round-robin
//  IN_VALID   in   1      producer has a word
//  IN_READY   out  1      dispatcher can accept a word this cycle
//  IN_DATA    in   WIDTH  producer word
//  IN_SEL     in   1      target output in steer mode (0 -> OUT0, 1 -> OUT1)
//  OUT0_VALID out  1      word valid on OUT0
//  OUT0_READY in   1      consumer 0 accepts
//  OUT0_DATA  out  WIDTH  buffered word when targeting OUT0, else 0
//  OUT1_VALID out  1      word valid on OUT1
//  OUT1_READY in   1      consumer 1 accepts
//  OUT1_DATA  out  WIDTH  buffered word when targeting OUT1, else 0
//  CNT0       out  CNT_W  words delivered on OUT0 (DISPATCH_COUNT_EN only)
//  CNT1       out  CNT_W  words delivered on OUT1 (DISPATCH_COUNT_EN only)
// BEHAVIOUR
//  State and outputs:
//  - State: EMPTY / FULL, plus tgt (1b), rr_ptr (1b) and buf (WIDTH).
//  - Reset values: EMPTY, tgt=0, rr_ptr=0, buf=0.
//    Outputs: IN_READY=1, OUT*_VALID=0, OUT*_DATA=0, CNT*=0.
//  Handshakes:
//  - pop  = FULL & ((tgt==0 & OUT0_READY) | (tgt==1 & OUT1_READY)).
//  - IN_READY = EMPTY | pop (combinational bypass of the pop).
//  - push = IN_VALID & IN_READY.
//  Capture (on push):
//  - buf <= IN_DATA.
//  - tgt <= MODE ? rr_ptr : IN_SEL.
//  - In MODE=1, rr_ptr toggles on every push. rr_ptr is untouched in MODE=0.
//  Transitions:
//  - EMPTY -push-> FULL.
//  - FULL -pop & ~push-> EMPTY.
//  - FULL -pop & push-> FULL with the new word (back-to-back, 1 word/cycle sustained).
//  - FULL & ~pop: hold; buf and tgt stable.
//  Outputs:
//  - OUT0_VALID = FULL & ~tgt; OUT1_VALID = FULL & tgt.
//  - Data gated: OUTn_DATA = OUTn_VALID ? buf : 0.
//  Timing and ordering:
//  - Latency: a word pushed in cycle N is presented in cycle N+1.
//  - Target is fixed at capture. No reordering, and no skip to the other output while stalled (head-of-line blocking is intended).
//  - The READY of the non-targeted consumer is ignored.
//  - VALID never drops without a pop; data stays stable while VALID=1 and READY=0.
//  Boundaries:
//  - MODE change mid-stream affects only subsequent pushes.
//  - rr_ptr keeps its value across MODE toggles.
//  - RST asserted mid-operation: the buffered word is discarded and all state returns to reset values on the next edge. RST dominates push.
// CONFIGURATION
//  DISPATCH_COUNT_EN defined:
//  - CNT0 and CNT1 increment on each pop to their respective output.
//  - Counters wrap modulo 2^CNT_W and reset to 0.
//  DISPATCH_COUNT_EN undefined:
//  - Counter logic is absent.
//  - CNT0 and CNT1 are tied to 0. Ports remain, so the interface is identical.
// TESTING
//  1. RST=1 for 2 cycles, then release -> IN_READY=1, OUT0/1_VALID=0, OUT0/1_DATA=0, CNT0/1=0.
//  2. MODE=0, IN_SEL=1, IN_DATA=8'hA5, one push, OUT1_READY=1
//     -> next cycle OUT1_VALID=1, OUT1_DATA=A5, OUT0_VALID=0, OUT0_DATA=0.
//  3. MODE=1, both READY=1, push 01,02,03,04 back-to-back
//     -> OUT0 gets 01,03 and OUT1 gets 02,04, one per cycle, IN_READY held 1.
//  4. MODE=0, IN_SEL=0, push 8'h11, OUT0_READY=0 for 3 cycles, OUT1_READY=1
//     -> IN_READY=0 and OUT0_DATA=11 stable for 3 cycles; on OUT0_READY=1 -> pop, IN_READY=1.
//  5. MODE=1, FULL with tgt=1, RST pulsed 1 cycle
//     -> next cycle OUT1_VALID=0, IN_READY=1; the next push goes to OUT0 (rr_ptr=0).
//  6. With DISPATCH_COUNT_EN, CNT_W=8, push 300 words with MODE=0, IN_SEL=0
//     -> CNT0=44 (wrapped), CNT1=0.

Source files
------------

// File: rtl/demux_stream_dispatcher_if.sv
// Stream bundle between one producer, the dispatcher and two consumers.
// The slave modport is the dispatcher's view; the master modport is the surrounding logic's view.
interface demux_stream_dispatcher_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic             mode;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] out0_data;
  logic             out1_valid;
  logic             out1_ready;
  logic [WIDTH-1:0] out1_data;
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;

  modport slave (
    input  mode, in_valid, in_data, in_sel, out0_ready, out1_ready,
    output in_ready, out0_valid, out0_data, out1_valid, out1_data, cnt0, cnt1
  );

  modport master (
    output mode, in_valid, in_data, in_sel, out0_ready, out1_ready,
    input  in_ready, out0_valid, out0_data, out1_valid, out1_data, cnt0, cnt1
  );
endinterface

// File: rtl/demux_stream_dispatcher.sv
// One-entry buffered 1-to-2 stream dispatcher, steered by in_sel or round-robin.
// Optional per-output delivery counters are enabled with the DISPATCH_COUNT_EN macro.
module demux_stream_dispatcher #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input logic                      clk,
  input logic                      rst,
  demux_stream_dispatcher_if.slave bus
);
  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_e;

  state_e           state_q;
  logic             tgt_q;
  logic             rr_q;
  logic [WIDTH-1:0] buf_q;

  logic full;
  logic pop;
  logic push;
  logic in_ready;

  assign full     = (state_q == ST_FULL);
  // Only the targeted consumer's ready matters; the other one is ignored.
  assign pop      = full & (tgt_q ? bus.out1_ready : bus.out0_ready);
  assign in_ready = ~full | pop;
  assign push     = bus.in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      tgt_q   <= 1'b0;
      rr_q    <= 1'b0;
      buf_q   <= '0;
    end else if (push) begin
      state_q <= ST_FULL;
      buf_q   <= bus.in_data;
      tgt_q   <= bus.mode ? rr_q : bus.in_sel;
      if (bus.mode) begin
        rr_q <= ~rr_q;
      end
    end else if (pop) begin
      state_q <= ST_EMPTY;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out0_valid = full & ~tgt_q;
  assign bus.out1_valid = full & tgt_q;
  assign bus.out0_data  = (full & ~tgt_q) ? buf_q : '0;
  assign bus.out1_data  = (full & tgt_q) ? buf_q : '0;

`ifdef DISPATCH_COUNT_EN
  logic [CNT_W-1:0] cnt0_q;
  logic [CNT_W-1:0] cnt1_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else if (pop) begin
      if (tgt_q) begin
        cnt1_q <= cnt1_q + 1'b1;
      end else begin
        cnt0_q <= cnt0_q + 1'b1;
      end
    end
  end

  assign bus.cnt0 = cnt0_q;
  assign bus.cnt1 = cnt1_q;
`else
  assign bus.cnt0 = {CNT_W{1'b0}};
  assign bus.cnt1 = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_demux_stream_dispatcher.sv
// Bench for demux_stream_dispatcher: directed vector table, reset/wrap sequences,
// and randomized traffic checked against a queue-based reference model.
module tb_demux_stream_dispatcher;
  localparam int WIDTH = 8;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  demux_stream_dispatcher_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  demux_stream_dispatcher #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic       mode;
    logic       valid;
    logic [7:0] data;
    logic       sel;
    logic       r0;
    logic       r1;
    logic       e_ready;
    logic       e_v0;
    logic [7:0] e_d0;
    logic       e_v1;
    logic [7:0] e_d1;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic       tgt;
  } item_t;

  vec_t  vecs[13];
  int    n_vec  = 0;
  int    n_miss = 0;

  // Reference model: pending words in order, count of round-robin pushes, deliveries per output.
  item_t m_q[$];
  int    m_rr_pushes;
  int    m_cnt0;
  int    m_cnt1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic r, input logic mode, input logic valid,
                        input logic [7:0] data, input logic sel,
                        input logic r0, input logic r1);
    rst            = r;
    bus.mode       = mode;
    bus.in_valid   = valid;
    bus.in_data    = data;
    bus.in_sel     = sel;
    bus.out0_ready = r0;
    bus.out1_ready = r1;
  endtask

  task automatic m_reset();
    m_q.delete();
    m_rr_pushes = 0;
    m_cnt0      = 0;
    m_cnt1      = 0;
  endtask

  function automatic logic m_pop();
    if (m_q.size() == 0) return 1'b0;
    return m_q[0].tgt ? bus.out1_ready : bus.out0_ready;
  endfunction

  task automatic model_check(input string tag);
    logic       ev0, ev1, er;
    logic [7:0] ed0, ed1;
    int         ec0, ec1;
    ev0 = (m_q.size() > 0) && !m_q[0].tgt;
    ev1 = (m_q.size() > 0) && m_q[0].tgt;
    ed0 = ev0 ? m_q[0].data : 8'h00;
    ed1 = ev1 ? m_q[0].data : 8'h00;
    er  = (m_q.size() == 0) || m_pop();
`ifdef DISPATCH_COUNT_EN
    ec0 = m_cnt0 % 256;
    ec1 = m_cnt1 % 256;
`else
    ec0 = 0;
    ec1 = 0;
`endif
    check({tag, ".in_ready"}, 32'(bus.in_ready), 32'(er));
    check({tag, ".out0_valid"}, 32'(bus.out0_valid), 32'(ev0));
    check({tag, ".out0_data"}, 32'(bus.out0_data), 32'(ed0));
    check({tag, ".out1_valid"}, 32'(bus.out1_valid), 32'(ev1));
    check({tag, ".out1_data"}, 32'(bus.out1_data), 32'(ed1));
    check({tag, ".cnt0"}, 32'(bus.cnt0), 32'(ec0));
    check({tag, ".cnt1"}, 32'(bus.cnt1), 32'(ec1));
  endtask

  // Advance one clock, updating the model from the inputs currently driven.
  task automatic tick();
    logic p, er, pu;
    if (rst) begin
      m_reset();
    end else begin
      p  = m_pop();
      er = (m_q.size() == 0) || p;
      pu = bus.in_valid && er;
      if (p) begin
        if (m_q[0].tgt) m_cnt1++;
        else            m_cnt0++;
        $display("pop  out%0d data=%02h", m_q[0].tgt, m_q[0].data);
        void'(m_q.pop_front());
      end
      if (pu) begin
        m_q.push_back('{data: bus.in_data,
                        tgt: bus.mode ? m_rr_pushes[0] : bus.in_sel});
        if (bus.mode) m_rr_pushes++;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cyc(input string tag, input logic r, input logic mode, input logic valid,
                     input logic [7:0] data, input logic sel,
                     input logic r0, input logic r1);
    set_in(r, mode, valid, data, sel, r0, r1);
    #1;
    model_check(tag);
    tick();
  endtask

  task automatic do_reset();
    set_in(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    m_reset();
    rst = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00};
    vecs[1]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'hA5};
    vecs[2]  = '{1'b1, 1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00};
    vecs[3]  = '{1'b1, 1'b1, 8'h02, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h01, 1'b0, 8'h00};
    vecs[4]  = '{1'b1, 1'b1, 8'h03, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h02};
    vecs[5]  = '{1'b1, 1'b1, 8'h04, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h03, 1'b0, 8'h00};
    vecs[6]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h04};
    vecs[7]  = '{1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00};
    vecs[8]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 8'h00};
    vecs[9]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 8'h00};
    vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 8'h00};
    vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h11, 1'b0, 8'h00};
    vecs[12] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00};

    // Reset state
    do_reset();
    #1;
    check("reset.in_ready", 32'(bus.in_ready), 32'd1);
    check("reset.out0_valid", 32'(bus.out0_valid), 32'd0);
    check("reset.out1_valid", 32'(bus.out1_valid), 32'd0);
    check("reset.out0_data", 32'(bus.out0_data), 32'd0);
    check("reset.out1_data", 32'(bus.out1_data), 32'd0);
    check("reset.cnt0", 32'(bus.cnt0), 32'd0);
    check("reset.cnt1", 32'(bus.cnt1), 32'd0);

    // Directed table: steer, round-robin back-to-back, head-of-line stall
    for (int i = 0; i < 13; i++) begin
      set_in(1'b0, vecs[i].mode, vecs[i].valid, vecs[i].data, vecs[i].sel, vecs[i].r0, vecs[i].r1);
      #1;
      $display("vec %0d: mode=%0d valid=%0d data=%02h sel=%0d r0=%0d r1=%0d", i,
               vecs[i].mode, vecs[i].valid, vecs[i].data, vecs[i].sel, vecs[i].r0, vecs[i].r1);
      check($sformatf("vec%0d.in_ready", i), 32'(bus.in_ready), 32'(vecs[i].e_ready));
      check($sformatf("vec%0d.out0_valid", i), 32'(bus.out0_valid), 32'(vecs[i].e_v0));
      check($sformatf("vec%0d.out0_data", i), 32'(bus.out0_data), 32'(vecs[i].e_d0));
      check($sformatf("vec%0d.out1_valid", i), 32'(bus.out1_valid), 32'(vecs[i].e_v1));
      check($sformatf("vec%0d.out1_data", i), 32'(bus.out1_data), 32'(vecs[i].e_d1));
      @(negedge clk);
    end

    // Reset while FULL toward OUT1: word discarded, rr pointer back to OUT0, reset beats push
    do_reset();
    cyc("rst_mid.a", 1'b0, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b1, 1'b0);
    cyc("rst_mid.b", 1'b0, 1'b1, 1'b1, 8'hC3, 1'b0, 1'b1, 1'b0);
    set_in(1'b1, 1'b1, 1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
    #1;
    check("rst_mid.held_v1", 32'(bus.out1_valid), 32'd1);
    check("rst_mid.held_d1", 32'(bus.out1_data), 32'hC3);
    tick();
    set_in(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    #1;
    check("rst_mid.after_v1", 32'(bus.out1_valid), 32'd0);
    check("rst_mid.after_v0", 32'(bus.out0_valid), 32'd0);
    check("rst_mid.after_ready", 32'(bus.in_ready), 32'd1);
    tick();
    cyc("rst_mid.c", 1'b0, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
    set_in(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    #1;
    check("rst_mid.next_v0", 32'(bus.out0_valid), 32'd1);
    check("rst_mid.next_d0", 32'(bus.out0_data), 32'h3C);
    check("rst_mid.next_v1", 32'(bus.out1_valid), 32'd0);
    tick();

    // 300 steered words to OUT0: counter wraps when enabled
    do_reset();
    for (int i = 0; i < 300; i++) begin
      cyc("wrap", 1'b0, 1'b0, 1'b1, 8'(i), 1'b0, 1'b1, 1'b0);
    end
    cyc("wrap.drain", 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    #1;
`ifdef DISPATCH_COUNT_EN
    check("wrap.cnt0", 32'(bus.cnt0), 32'd44);
`else
    check("wrap.cnt0", 32'(bus.cnt0), 32'd0);
`endif
    check("wrap.cnt1", 32'(bus.cnt1), 32'd0);
    check("wrap.empty_ready", 32'(bus.in_ready), 32'd1);

    // Randomized traffic, including mode flips and occasional resets
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      cyc("rand",
          ($urandom_range(0, 99) == 0),
          ($urandom_range(0, 7) < 4),
          ($urandom_range(0, 9) < 7),
          8'($urandom),
          1'($urandom),
          ($urandom_range(0, 9) < 6),
          ($urandom_range(0, 9) < 6));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
